// File: rtl/riscv_mem_pkg.sv
// Shared types and defaults for the instruction/data memory arbiter.
package riscv_mem_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2
  } arb_state_t;

  localparam int unsigned MAX_WAIT_DEFAULT = 4;

endpackage

// File: rtl/mem_arb_starve_cnt.sv
// Counts back-to-back data grants while instruction fetch waits; flags when
// the fetch side must be served next. Only instantiated with MEM_ARB_STARVE_GUARD_EN.
module mem_arb_starve_cnt
  import riscv_mem_pkg::*;
#(
  parameter int unsigned MAX_WAIT = MAX_WAIT_DEFAULT
) (
  input  logic clock,
  input  logic reset,
  input  logic idle,
  input  logic if_req,
  input  logic d_gnt_evt,
  input  logic i_gnt_evt,
  output logic starve
);

  localparam int unsigned CW = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(MAX_WAIT);

  logic [CW-1:0] cnt_q, cnt_d;

  // A data grant with if_req low lands in the idle/no-fetch clear branch.
  always_comb begin
    cnt_d = cnt_q;
    if (i_gnt_evt || (idle && !if_req)) begin
      cnt_d = '0;
    end else if (d_gnt_evt && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign starve = (cnt_q == CNT_MAX);

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates instruction-fetch and load/store requesters onto one memory port.
// Optional fetch starvation guard enabled by MEM_ARB_STARVE_GUARD_EN.
//
// state  | meaning
// IDLE   | no transaction; arbitrate pending requests
// BUSY_I | instruction fetch owns the memory port
// BUSY_D | load/store owns the memory port
module mem_arbiter
  import riscv_mem_pkg::*;
#(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned MAX_WAIT = MAX_WAIT_DEFAULT
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              if_req,
  input  logic [DATA_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [DATA_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ready,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  arb_state_t        state_q, state_d;
  logic [DATA_W-1:0] addr_q, addr_d, wdata_q, wdata_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d, d_rdata_q, d_rdata_d;
  logic              we_q, we_d;
  logic              if_gnt_q, if_gnt_d, d_gnt_q, d_gnt_d;
  logic              if_rvalid_q, if_rvalid_d, d_rvalid_q, d_rvalid_d;
  logic              starve, pick_i, pick_d;

`ifdef MEM_ARB_STARVE_GUARD_EN
  mem_arb_starve_cnt #(.MAX_WAIT(MAX_WAIT)) u_starve_cnt (
    .clock     (clock),
    .reset     (reset),
    .idle      (state_q == IDLE),
    .if_req    (if_req),
    .d_gnt_evt (d_gnt_d),
    .i_gnt_evt (if_gnt_d),
    .starve    (starve)
  );
`else
  logic unused_max_wait;
  assign unused_max_wait = |MAX_WAIT;
  assign starve = 1'b0;
`endif

  // Data wins unless fetch has waited out its allowance.
  assign pick_i = if_req && (!d_req || starve);
  assign pick_d = d_req && !pick_i;

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    we_d        = we_q;
    if_gnt_d    = 1'b0;
    d_gnt_d     = 1'b0;
    if_rvalid_d = 1'b0;
    d_rvalid_d  = 1'b0;
    if_rdata_d  = if_rdata_q;
    d_rdata_d   = d_rdata_q;
    case (state_q)
      IDLE: begin
        if (pick_i) begin
          state_d  = BUSY_I;
          addr_d   = if_addr;
          wdata_d  = '0;
          we_d     = 1'b0;
          if_gnt_d = 1'b1;
        end else if (pick_d) begin
          state_d = BUSY_D;
          addr_d  = d_addr;
          wdata_d = d_wdata;
          we_d    = d_we;
          d_gnt_d = 1'b1;
        end
      end
      BUSY_I: begin
        if (mem_ready) begin
          state_d     = IDLE;
          addr_d      = '0;
          wdata_d     = '0;
          we_d        = 1'b0;
          if_rvalid_d = 1'b1;
          if_rdata_d  = mem_rdata;
        end
      end
      BUSY_D: begin
        if (mem_ready) begin
          state_d    = IDLE;
          addr_d     = '0;
          wdata_d    = '0;
          we_d       = 1'b0;
          d_rvalid_d = 1'b1;
          d_rdata_d  = we_q ? '0 : mem_rdata;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      wdata_q     <= '0;
      we_q        <= 1'b0;
      if_gnt_q    <= 1'b0;
      d_gnt_q     <= 1'b0;
      if_rvalid_q <= 1'b0;
      d_rvalid_q  <= 1'b0;
      if_rdata_q  <= '0;
      d_rdata_q   <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      we_q        <= we_d;
      if_gnt_q    <= if_gnt_d;
      d_gnt_q     <= d_gnt_d;
      if_rvalid_q <= if_rvalid_d;
      d_rvalid_q  <= d_rvalid_d;
      if_rdata_q  <= if_rdata_d;
      d_rdata_q   <= d_rdata_d;
    end
  end

  assign if_gnt    = if_gnt_q;
  assign d_gnt     = d_gnt_q;
  assign if_rvalid = if_rvalid_q;
  assign d_rvalid  = d_rvalid_q;
  assign if_rdata  = if_rdata_q;
  assign d_rdata   = d_rdata_q;
  assign mem_req   = (state_q != IDLE);
  assign busy      = (state_q != IDLE);
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign mem_we    = we_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: transaction-level model checked every
// negedge, plus directed scenarios with hand-computed expectations.
module tb_mem_arbiter;

  localparam int DATA_W   = 32;
  localparam int MAX_WAIT = 4;
`ifdef MEM_ARB_STARVE_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  logic              clock = 1'b0;
  logic              reset = 1'b0;
  logic              if_req = 1'b0, d_req = 1'b0, d_we = 1'b0, mem_ready = 1'b0;
  logic [DATA_W-1:0] if_addr = '0, d_addr = '0, d_wdata = '0, mem_rdata = '0;
  logic              if_gnt, if_rvalid, d_gnt, d_rvalid, mem_req, mem_we, busy;
  logic [DATA_W-1:0] if_rdata, d_rdata, mem_addr, mem_wdata;

  mem_arbiter #(.DATA_W(DATA_W), .MAX_WAIT(MAX_WAIT)) dut (
    .clock(clock), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata), .busy(busy)
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Transaction-level model: owner 0 = none, 1 = fetch, 2 = load/store.
  int          m_owner = 0;
  int          m_cnt   = 0;
  logic [31:0] m_addr = '0, m_wdata = '0, m_we = '0;
  logic [31:0] e_if_gnt = '0, e_d_gnt = '0, e_if_rvalid = '0, e_d_rvalid = '0;
  logic [31:0] e_if_rdata = '0, e_d_rdata = '0;

  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      m_owner = 0; m_cnt = 0; m_addr = '0; m_wdata = '0; m_we = '0;
      e_if_gnt = '0; e_d_gnt = '0; e_if_rvalid = '0; e_d_rvalid = '0;
      e_if_rdata = '0; e_d_rdata = '0;
    end else begin
      e_if_gnt = '0; e_d_gnt = '0; e_if_rvalid = '0; e_d_rvalid = '0;
      if (m_owner == 0) begin
        if (d_req && !(GUARD && if_req && (m_cnt >= MAX_WAIT))) begin
          m_owner = 2; m_addr = d_addr; m_wdata = d_wdata; m_we = 32'(d_we); e_d_gnt = 32'd1;
          m_cnt = if_req ? ((m_cnt < MAX_WAIT) ? m_cnt + 1 : MAX_WAIT) : 0;
        end else if (if_req) begin
          m_owner = 1; m_addr = if_addr; m_wdata = '0; m_we = '0; e_if_gnt = 32'd1;
          m_cnt = 0;
        end else begin
          m_cnt = 0;
        end
      end else if (mem_ready) begin
        if (m_owner == 1) begin
          e_if_rvalid = 32'd1; e_if_rdata = mem_rdata;
        end else begin
          e_d_rvalid = 32'd1; e_d_rdata = (m_we != 0) ? 32'd0 : mem_rdata;
        end
        m_owner = 0; m_addr = '0; m_wdata = '0; m_we = '0;
      end
    end
  end

  always @(negedge clock) begin
    chk("if_gnt",    32'(if_gnt),    e_if_gnt);
    chk("d_gnt",     32'(d_gnt),     e_d_gnt);
    chk("if_rvalid", 32'(if_rvalid), e_if_rvalid);
    chk("d_rvalid",  32'(d_rvalid),  e_d_rvalid);
    chk("if_rdata",  if_rdata,       e_if_rdata);
    chk("d_rdata",   d_rdata,        e_d_rdata);
    chk("mem_req",   32'(mem_req),   (m_owner != 0) ? 32'd1 : 32'd0);
    chk("busy",      32'(busy),      (m_owner != 0) ? 32'd1 : 32'd0);
    chk("mem_addr",  mem_addr,       m_addr);
    chk("mem_wdata", mem_wdata,      m_wdata);
    chk("mem_we",    32'(mem_we),    m_we);
  end

  task automatic tick();
    @(posedge clock);
    #2;
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  int   ngr;
  int   n_i;
  logic exp_i;

  initial begin
    repeat (2) tick();
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_busy",    32'(busy),    32'd0);
    chk("rst_if_rdata", if_rdata,    32'd0);
    reset = 1'b1;

    // Single fetch at minimum latency.
    if_req = 1'b1; if_addr = 32'h100;
    tick();
    chk("t1_if_gnt",   32'(if_gnt),  32'd1);
    chk("t1_mem_addr", mem_addr,     32'h100);
    chk("t1_busy",     32'(busy),    32'd1);
    if_req = 1'b0; if_addr = '0; mem_ready = 1'b1; mem_rdata = 32'h00500093;
    tick();
    chk("t1_if_rvalid", 32'(if_rvalid), 32'd1);
    chk("t1_if_rdata",  if_rdata,       32'h00500093);
    chk("t1_idle",      32'(mem_req),   32'd0);
    mem_ready = 1'b0; mem_rdata = '0;
    tick();
    chk("t1_rvalid_pulse", 32'(if_rvalid), 32'd0);
    chk("t1_rdata_hold",   if_rdata,       32'h00500093);

    // Both request; data write wins, then fetch.
    if_req = 1'b1; if_addr = 32'h104;
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h2000; d_wdata = 32'hDEADBEEF;
    tick();
    chk("t2_d_gnt",     32'(d_gnt),  32'd1);
    chk("t2_if_gnt",    32'(if_gnt), 32'd0);
    chk("t2_mem_we",    32'(mem_we), 32'd1);
    chk("t2_mem_wdata", mem_wdata,   32'hDEADBEEF);
    chk("t2_mem_addr",  mem_addr,    32'h2000);
    d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
    mem_ready = 1'b1; mem_rdata = 32'h12345678;
    tick();
    chk("t2_d_rvalid", 32'(d_rvalid), 32'd1);
    chk("t2_d_rdata",  d_rdata,       32'd0);
    mem_ready = 1'b0;
    tick();
    chk("t2_if_gnt_after", 32'(if_gnt), 32'd1);
    chk("t2_if_addr",      mem_addr,    32'h104);
    if_req = 1'b0; if_addr = '0; mem_ready = 1'b1; mem_rdata = 32'h000000AA;
    tick();
    chk("t2_if_rdata", if_rdata, 32'h000000AA);
    mem_ready = 1'b0;

    // Slow memory: ready held low for 5 busy cycles.
    d_req = 1'b1; d_addr = 32'h3000;
    tick();
    chk("t3_d_gnt", 32'(d_gnt), 32'd1);
    d_req = 1'b0; d_addr = '0;
    for (int i = 0; i < 5; i++) begin
      chk("t3_mem_req",  32'(mem_req),  32'd1);
      chk("t3_mem_addr", mem_addr,      32'h3000);
      chk("t3_busy",     32'(busy),     32'd1);
      chk("t3_no_rv",    32'(d_rvalid), 32'd0);
      tick();
    end
    mem_ready = 1'b1; mem_rdata = 32'hCAFEF00D;
    chk("t3_still_busy", 32'(busy), 32'd1);
    tick();
    chk("t3_d_rvalid", 32'(d_rvalid), 32'd1);
    chk("t3_d_rdata",  d_rdata,       32'hCAFEF00D);

    // Ready pulsed while idle: nothing happens.
    mem_rdata = 32'h55;
    tick();
    chk("t4_busy",      32'(busy),      32'd0);
    chk("t4_d_rvalid",  32'(d_rvalid),  32'd0);
    tick();
    chk("t4_if_rvalid", 32'(if_rvalid), 32'd0);
    chk("t4_d_rdata",   d_rdata,        32'hCAFEF00D);
    mem_ready = 1'b0;
    tick();

    // Continuous contention: guard gives D,D,D,D,I pattern; otherwise data only.
    d_req = 1'b1; d_addr = 32'h40; if_req = 1'b1; if_addr = 32'h80;
    mem_ready = 1'b1; mem_rdata = 32'h77;
    ngr = 0; n_i = 0;
    for (int c = 0; c < 60 && ngr < 20; c++) begin
      tick();
      if (d_gnt || if_gnt) begin
        exp_i = GUARD && ((ngr % 5) == 4);
        chk("t5_grant_kind", 32'(if_gnt), 32'(exp_i));
        if (if_gnt) n_i++;
        ngr++;
      end
    end
    chk("t5_grant_count", 32'(ngr), 32'd20);
    chk("t5_instr_grants", 32'(n_i), GUARD ? 32'd4 : 32'd0);
    d_req = 1'b0; if_req = 1'b0; d_addr = '0; if_addr = '0;
    tick();
    mem_ready = 1'b0;
    tick();

    // Reset in the middle of a fetch.
    if_req = 1'b1; if_addr = 32'h400;
    tick();
    chk("t6_if_gnt", 32'(if_gnt), 32'd1);
    if_req = 1'b0; if_addr = '0;
    tick();
    chk("t6_busy_pre", 32'(busy), 32'd1);
    reset = 1'b0; mem_ready = 1'b1; mem_rdata = 32'h99;
    #1;
    chk("t6_mem_req_rst", 32'(mem_req), 32'd0);
    chk("t6_busy_rst",    32'(busy),    32'd0);
    chk("t6_addr_rst",    mem_addr,     32'd0);
    tick();
    chk("t6_if_rdata_rst", if_rdata, 32'd0);
    reset = 1'b1; mem_ready = 1'b0; if_req = 1'b1; if_addr = 32'h500;
    tick();
    chk("t6_no_rvalid", 32'(if_rvalid), 32'd0);
    chk("t6_fresh_gnt", 32'(if_gnt),    32'd1);
    chk("t6_fresh_addr", mem_addr,      32'h500);
    if_req = 1'b0; if_addr = '0; mem_ready = 1'b1; mem_rdata = 32'h1234;
    tick();
    chk("t6_if_rdata", if_rdata, 32'h1234);
    mem_ready = 1'b0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
